jtflane_rom_fetch: RTL and testbench



---
 rtl/jtflane_rom_fetch_pkg.sv | 17 +
 rtl/jtflane_rom_fetch_if.sv | 29 ++
 rtl/jtflane_rom_fetch_ram.sv | 25 ++
 rtl/jtflane_rom_fetch.sv | 124 ++++++++++++
 tb/tb_jtflane_rom_fetch.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/jtflane_rom_fetch_pkg.sv
// Shared types and default geometry for the Fast Lane main ROM fetcher.
// Line cache state encodings and the default address split widths.
package jtflane_rom_fetch_pkg;

  localparam int LINES_DEF = 16;
  localparam int BURST_DEF = 4;
  localparam int IDXW = $clog2(LINES_DEF);
  localparam int OFFW = $clog2(BURST_DEF);
  localparam int TAGW = 16 - IDXW - OFFW;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_FILL = 2'd2
  } state_t;

endpackage

// File: rtl/jtflane_rom_fetch_if.sv
// CPU ROM port plus SDRAM burst port of the main ROM fetcher.
// slave is the fetcher side, master is the CPU/SDRAM side.
interface jtflane_rom_fetch_if #(
  parameter int SDRAM_AW = 22
);
  logic                rom_cs;
  logic [16:0]         rom_addr;
  logic [7:0]          rom_data;
  logic                rom_ok;
  logic                sdram_req;
  logic [SDRAM_AW-1:0] sdram_addr;
  logic                sdram_ack;
  logic                sdram_dst;
  logic [15:0]         sdram_data;

  modport slave (
    input  rom_cs, rom_addr,
    input  sdram_ack, sdram_dst, sdram_data,
    output rom_data, rom_ok,
    output sdram_req, sdram_addr
  );

  modport master (
    output rom_cs, rom_addr,
    output sdram_ack, sdram_dst, sdram_data,
    input  rom_data, rom_ok,
    input  sdram_req, sdram_addr
  );
endinterface

// File: rtl/jtflane_rom_fetch_ram.sv
// Line data store: write port fed by SDRAM bursts, registered read port.
// Shaped so synthesis maps it onto a simple dual-port block RAM.
module jtflane_rom_fetch_ram #(
  parameter int AW = 6
)(
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [15:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [15:0]   rdata
);
  logic [15:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/jtflane_rom_fetch.sv
// Main CPU ROM responder with a direct-mapped line cache over SDRAM.
// Hits answer one clock later; misses fetch one burst into a line.
module jtflane_rom_fetch
  import jtflane_rom_fetch_pkg::*;
#(
  parameter int                  SDRAM_AW = 22,
  parameter logic [SDRAM_AW-1:0] BASE     = '0,
  parameter int                  LINES    = LINES_DEF,
  parameter int                  BURST    = BURST_DEF
)(
  input logic clk,
  input logic rst,
  jtflane_rom_fetch_if.slave bus
);
  localparam int IW = $clog2(LINES);
  localparam int OW = $clog2(BURST);
  localparam int TW = 16 - IW - OW;

  state_t state, nx;

  logic [OW-1:0] word;
  logic [IW-1:0] index;
  logic [TW-1:0] tag;

  logic [LINES-1:0] valid;
  logic [TW-1:0]    tag_q [LINES];

  logic [IW-1:0]       fill_index;
  logic [TW-1:0]       fill_tag;
  logic [OW-1:0]       cnt;
  logic [SDRAM_AW-1:0] addr_q;
  logic [16:0]         addr_r;
  logic                ok_r;
  logic [15:0]         rd_q;

  logic hit, start, we, last, req;

  assign word  = bus.rom_addr[OW:1];
  assign index = bus.rom_addr[OW+IW:OW+1];
  assign tag   = bus.rom_addr[16:OW+IW+1];

  assign hit   = bus.rom_cs && valid[index]
               && tag_q[index] == tag;
  assign start = state == ST_IDLE
               && bus.rom_cs && !hit;

  // ack may carry the first word in the same cycle
  assign we   = bus.sdram_dst
              && (state == ST_FILL
              || (state == ST_REQ && bus.sdram_ack));
  assign last = we && cnt == OW'(BURST - 1);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= nx;
  end

  always_comb begin
    nx = state;
    unique case (state)
      ST_IDLE: if (start) nx = ST_REQ;
      ST_REQ: begin
        if (bus.sdram_ack)
          nx = last ? ST_IDLE : ST_FILL;
      end
      ST_FILL: if (last) nx = ST_IDLE;
      default: nx = ST_IDLE;
    endcase
  end

  always_comb begin
    req = state == ST_REQ;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid      <= '0;
      fill_index <= '0;
      fill_tag   <= '0;
      cnt        <= '0;
      addr_q     <= '0;
      addr_r     <= '0;
      ok_r       <= 1'b0;
    end else begin
      // invalidate first so a half-written line never hits
      if (start) begin
        valid[index] <= 1'b0;
        fill_index   <= index;
        fill_tag     <= tag;
        cnt          <= '0;
        addr_q       <= BASE
          + SDRAM_AW'({tag, index, {OW{1'b0}}});
      end
      if (we)   cnt <= cnt + 1'b1;
      if (last) valid[fill_index] <= 1'b1;
      ok_r <= hit;
      if (hit) addr_r <= bus.rom_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (last) tag_q[fill_index] <= fill_tag;
  end

  jtflane_rom_fetch_ram #(
    .AW (IW + OW)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .waddr ({fill_index, cnt}),
    .wdata (bus.sdram_data),
    .re    (hit),
    .raddr ({index, word}),
    .rdata (rd_q)
  );

  assign bus.sdram_req  = req;
  assign bus.sdram_addr = addr_q;
  assign bus.rom_ok     = ok_r && bus.rom_cs
                        && bus.rom_addr == addr_r;
  assign bus.rom_data   = addr_r[0] ? rd_q[15:8]
                                    : rd_q[7:0];
endmodule

// File: tb/tb_jtflane_rom_fetch.sv
// Directed bench for the main ROM fetcher with a per-cycle cache model.
// SDRAM word contents come from a bench-side table plus a fixed generator.
module tb_jtflane_rom_fetch;
  import jtflane_rom_fetch_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  jtflane_rom_fetch_if #(.SDRAM_AW(22)) bus ();

  jtflane_rom_fetch #(
    .SDRAM_AW (22),
    .BASE     (22'h0),
    .LINES    (16),
    .BURST    (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] ovr [int];
  bit          res_v [1<<IDXW];
  logic [TAGW-1:0] res_t [1<<IDXW];
  bit          prev_hit = 1'b0;
  logic [16:0] prev_addr = '0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] data_of(input int wa);
    logic [7:0] lo;
    if (ovr.exists(wa)) return ovr[wa];
    lo = wa[7:0];
    return {lo ^ 8'h3C, lo + 8'h11};
  endfunction

  function automatic logic [7:0] exp_byte(input logic [16:0] a);
    logic [15:0] w;
    w = data_of(int'(a[16:1]));
    return a[0] ? w[15:8] : w[7:0];
  endfunction

  // model: a line is resident from the cycle after its last word
  always @(negedge clk) begin
    logic [16:0] a;
    logic [IDXW-1:0] ix;
    bit hit_now, exp_ok;
    a  = bus.rom_addr;
    ix = a[OFFW+IDXW:OFFW+1];
    if (rst) begin
      prev_hit = 1'b0;
    end else begin
      hit_now = bus.rom_cs && res_v[ix]
             && res_t[ix] == a[16:OFFW+IDXW+1];
      exp_ok = prev_hit && bus.rom_cs && a == prev_addr;
      chk("rom_ok", bus.rom_ok, exp_ok);
      if (exp_ok) chk("rom_data", bus.rom_data, exp_byte(a));
      prev_hit  = hit_now;
      prev_addr = a;
    end
  end

  task automatic drv(input bit cs, input logic [16:0] a);
    @(posedge clk); #1;
    bus.rom_cs   = cs;
    bus.rom_addr = a;
  endtask

  task automatic pin(input string n, input bit ok,
                     input logic [7:0] d);
    @(negedge clk);
    chk({n, "_ok"}, bus.rom_ok, ok);
    if (ok) chk({n, "_data"}, bus.rom_data, d);
  endtask

  task automatic clear_model();
    for (int i = 0; i < (1<<IDXW); i++) res_v[i] = 1'b0;
  endtask

  task automatic fill(input logic [21:0] exp_wa, input bit same,
                      input bit drop, input int ndst);
    bit got;
    int k;
    logic [IDXW-1:0] ix;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.sdram_req) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      chk("req_timeout", 0, 1);
      return;
    end
    chk("sdram_addr", bus.sdram_addr, exp_wa);
    ix = exp_wa[OFFW+IDXW-1:OFFW];
    res_v[ix] = 1'b0;
    @(posedge clk); #1;
    bus.sdram_ack = 1'b1;
    k = 0;
    if (same) begin
      bus.sdram_dst  = 1'b1;
      bus.sdram_data = data_of(int'(exp_wa));
      k = 1;
    end
    @(posedge clk); #1;
    bus.sdram_ack = 1'b0;
    bus.sdram_dst = 1'b0;
    if (drop) bus.rom_cs = 1'b0;
    @(negedge clk);
    chk("req_drop", bus.sdram_req, 0);
    for (; k < ndst; k++) begin
      @(posedge clk); #1;
      bus.sdram_dst  = 1'b1;
      bus.sdram_data = data_of(int'(exp_wa) + k);
    end
    @(posedge clk); #1;
    bus.sdram_dst = 1'b0;
    if (ndst == 4) begin
      res_v[ix] = 1'b1;
      res_t[ix] = exp_wa[15:OFFW+IDXW];
    end
  endtask

  initial begin
    logic [7:0] lit [8];
    lit[0] = 8'hEF; lit[1] = 8'hBE; lit[2] = 8'h12; lit[3] = 8'h3D;
    lit[4] = 8'h13; lit[5] = 8'h3E; lit[6] = 8'h14; lit[7] = 8'h3F;
    ovr[32'h4000] = 16'h1211;
    ovr[32'h4001] = 16'h3433;
    ovr[32'h4002] = 16'h5655;
    ovr[32'h4003] = 16'h7877;
    ovr[0]        = 16'hBEEF;
    clear_model();
    bus.rom_cs     = 1'b0;
    bus.rom_addr   = '0;
    bus.sdram_ack  = 1'b0;
    bus.sdram_dst  = 1'b0;
    bus.sdram_data = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ok",   bus.rom_ok, 0);
    chk("rst_data", bus.rom_data, 0);
    chk("rst_req",  bus.sdram_req, 0);
    chk("rst_addr", bus.sdram_addr, 0);

    // first miss, hit two cycles after the last word
    drv(1, 17'h08000);
    fill(22'h4000, 0, 0, 4);
    pin("t1_l1", 0, 8'h00);
    pin("t1_hit", 1, 8'h11);

    drv(1, 17'h08003);
    pin("t2_a", 0, 8'h00);
    pin("t2_b", 1, 8'h34);
    chk("t2_noreq", bus.sdram_req, 0);
    drv(1, 17'h08007);
    pin("t2_gap", 0, 8'h00);
    pin("t2_c", 1, 8'h78);
    chk("t2_noreq2", bus.sdram_req, 0);

    // same index, different tag
    drv(1, 17'h08080);
    fill(22'h4040, 0, 0, 4);
    pin("t3_l1", 0, 8'h00);
    pin("t3_hit", 1, 8'h51);
    drv(1, 17'h08000);
    fill(22'h4000, 0, 0, 4);
    pin("t3_l2", 0, 8'h00);
    pin("t3_back", 1, 8'h11);

    // cs dropped during the burst
    drv(1, 17'h00118);
    fill(22'h008C, 0, 1, 4);
    repeat (3) begin
      @(negedge clk);
      chk("t4_idle_req", bus.sdram_req, 0);
    end
    drv(1, 17'h00118);
    pin("t4_a", 0, 8'h00);
    pin("t4_hit", 1, 8'h9D);
    chk("t4_noreq", bus.sdram_req, 0);

    // reset after two words
    drv(1, 17'h00210);
    fill(22'h0108, 0, 0, 2);
    @(posedge clk); #1;
    rst = 1'b1;
    clear_model();
    @(posedge clk); #1;
    rst = 1'b0;
    bus.rom_cs     = 1'b0;
    bus.sdram_dst  = 1'b1;
    bus.sdram_data = 16'hDEAD;
    @(negedge clk);
    chk("t5_req", bus.sdram_req, 0);
    chk("t5_ok",  bus.rom_ok, 0);
    @(posedge clk); #1;
    bus.sdram_dst = 1'b1;
    @(negedge clk);
    chk("t5_req2", bus.sdram_req, 0);
    @(posedge clk); #1;
    bus.sdram_dst = 1'b0;
    bus.rom_cs    = 1'b1;
    fill(22'h0108, 0, 0, 4);
    pin("t5_l1", 0, 8'h00);
    pin("t5_hit", 1, 8'h19);

    // ack and first word together
    @(posedge clk); #1;
    rst = 1'b1;
    clear_model();
    @(posedge clk); #1;
    rst = 1'b0;
    bus.rom_cs   = 1'b1;
    bus.rom_addr = 17'h00001;
    fill(22'h0000, 1, 0, 4);
    pin("t6_l1", 0, 8'h00);
    pin("t6_hit", 1, 8'hBE);
    for (int i = 0; i < 8; i++) begin
      drv(1, 17'(i));
      pin("t6_walk_a", 0, 8'h00);
      pin("t6_walk", 1, lit[i]);
    end
    chk("t6_noreq", bus.sdram_req, 0);

    drv(0, 17'h0);
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
